// File: rtl/key_debounce_if.sv
// Button-side signal bundle for key_debounce: raw pins in, conditioned level/pulse/event vectors out.
// All outputs are plain per-key levels or single-cycle pulses; there is no valid/ready handshake.
interface key_debounce_if;
    logic [3:0] KEY_RAW;
    logic [3:0] KEY_LEVEL;
    logic [3:0] KEY_PRESS;
    logic [3:0] KEY_EVT;
    logic [7:0] rpt_state_dbg;  // 2 bits per key, key i at [2*i +: 2]

    modport master (
        output KEY_RAW,
        input  KEY_LEVEL,
        input  KEY_PRESS,
        input  KEY_EVT,
        input  rpt_state_dbg
    );

    modport slave (
        input  KEY_RAW,
        output KEY_LEVEL,
        output KEY_PRESS,
        output KEY_EVT,
        output rpt_state_dbg
    );
endinterface

// File: rtl/key_debounce.sv
// Four-button conditioner: 2-flop sync, per-key stability debounce, press/auto-repeat pulses,
// and an event stretcher that holds a non-zero KEY code for HOLD cycles per load.
module key_debounce #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DB_CYCLES    = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int HOLD         = 4
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    key_debounce_if.slave bus
);
    localparam int DW      = $clog2(DB_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);
    localparam int HW      = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_WAIT   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    logic [3:0]    p_raw;
    logic [3:0]    sync1_q, sync_q;
    logic [3:0]    level_q, level_d, level_dly_q;
    logic [DW-1:0] db_cnt_q [4];
    logic [DW-1:0] db_cnt_d [4];
    rpt_state_e    rpt_state_q [4];
    logic [RW-1:0] rpt_cnt_q [4];
    logic [3:0]    press_q;
    logic [3:0]    evt_q, pend_q;
    logic [HW-1:0] hold_q;

    assign p_raw = ACTIVE_LOW ? ~bus.KEY_RAW : bus.KEY_RAW;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q     <= '0;
            sync_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q     <= p_raw;
            sync_q      <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            level_d[i]  = level_q[i];
            if (sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DW'(DB_CYCLES - 1)) level_d[i] = ~level_q[i];
                else db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
        end
    end

    // Release is tested on level_d so no pulse is issued on the cycle KEY_LEVEL falls.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            press_q <= '0;
            for (int i = 0; i < 4; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                rpt_cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= 1'b0;
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        if (level_q[i] && !level_dly_q[i]) begin
                            press_q[i]   <= 1'b1;
                            rpt_cnt_q[i] <= '0;
                            if (REPEAT_DELAY != 0) rpt_state_q[i] <= RPT_WAIT;
                        end
                    end
                    RPT_WAIT: begin
                        if (!level_d[i]) begin
                            rpt_state_q[i] <= RPT_IDLE;
                        end else if (rpt_cnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
                            press_q[i]     <= 1'b1;
                            rpt_cnt_q[i]   <= '0;
                            rpt_state_q[i] <= RPT_REPEAT;
                        end else begin
                            rpt_cnt_q[i] <= rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (!level_d[i]) begin
                            rpt_state_q[i] <= RPT_IDLE;
                        end else if (rpt_cnt_q[i] == RW'(REPEAT_RATE - 1)) begin
                            press_q[i]   <= 1'b1;
                            rpt_cnt_q[i] <= '0;
                        end else begin
                            rpt_cnt_q[i] <= rpt_cnt_q[i] + RW'(1);
                        end
                    end
                    default: rpt_state_q[i] <= RPT_IDLE;
                endcase
            end
        end
    end

    // A pulse landing on the clearing cycle is parked in pend_q and loaded on the next cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            evt_q  <= '0;
            pend_q <= '0;
            hold_q <= '0;
        end else if (evt_q == '0) begin
            pend_q <= '0;
            if ((press_q | pend_q) != '0) begin
                evt_q  <= press_q | pend_q;
                hold_q <= HW'(HOLD);
            end
        end else if (hold_q == HW'(1)) begin
            evt_q  <= '0;
            hold_q <= '0;
            pend_q <= press_q;
        end else begin
            evt_q  <= evt_q | press_q;
            hold_q <= hold_q - HW'(1);
        end
    end

    always_comb begin
        bus.rpt_state_dbg = '0;
        for (int i = 0; i < 4; i++) bus.rpt_state_dbg[2*i +: 2] = rpt_state_q[i];
    end

    assign bus.KEY_LEVEL = level_q;
    assign bus.KEY_PRESS = press_q;
    assign bus.KEY_EVT   = evt_q;
endmodule

// File: doc/key_debounce.md
# key_debounce

Input conditioning stage for the four push-buttons, sitting between the board pins and the AHB key peripheral's `KEY[3:0]` input. Each raw button is synchronised to HCLK, debounced with a per-key stability counter, and converted into press events with optional auto-repeat. Events are stretched into a held vector so the AHB key peripheral samples a clean, non-zero `KEY` code once per press or repeat.

## Interface
- `ACTIVE_LOW`, 1: raw buttons read 0 when pressed; 0 means they read 1 when pressed.
- `DB_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥2.
- `REPEAT_DELAY`, 25000000: held cycles before the first auto-repeat; 0 disables auto-repeat.
- `REPEAT_RATE`, 5000000: cycles between subsequent repeats; must be ≥1 when repeat is enabled.
- `HOLD`, 4: cycles each event vector stays on `KEY_EVT`; must be ≥1.
- `HCLK` input 1: system clock.
- `HRESETn` input 1: reset HRESETn, asynchronous, active-low; clock HCLK.
- `KEY_RAW` input 4: asynchronous button pins.
- `KEY_LEVEL` output 4: debounced pressed state, 1 = pressed.
- `KEY_PRESS` output 4: one-cycle pulse per accepted press or auto-repeat.
- `KEY_EVT` output 4: held event vector; connects to the AHB key peripheral's `KEY`.

## Operation
- Normalisation: `p = ACTIVE_LOW ? ~KEY_RAW : KEY_RAW`, passed through a two-flop synchroniser per bit, giving `s`.
- Debounce is per key and independent. The counter width is clog2(DB_CYCLES+1).
  - If `s == KEY_LEVEL`, the counter clears to 0.
  - Otherwise the counter increments.
  - When it would reach DB_CYCLES, `KEY_LEVEL` toggles and the counter clears.
  - A glitch shorter than DB_CYCLES never changes `KEY_LEVEL`.
- Press detect: `KEY_PRESS[i]` is registered and fires the cycle after `KEY_LEVEL[i]` rises. A release produces no event.
- Auto-repeat is per key, with states IDLE, WAIT, REPEAT.
  - IDLE → WAIT on a rising `KEY_LEVEL`, repeat counter cleared.
  - WAIT: count held cycles. At REPEAT_DELAY, pulse `KEY_PRESS` and go to REPEAT with the counter cleared.
  - REPEAT: pulse `KEY_PRESS` every REPEAT_RATE cycles.
  - Any state → IDLE when `KEY_LEVEL` falls.
  - With REPEAT_DELAY = 0 the FSM stays in IDLE.
- Event stretcher.
  - When `KEY_EVT == 0` and `KEY_PRESS != 0`: load `KEY_EVT <= KEY_PRESS` and the hold counter with HOLD.
  - When `KEY_EVT != 0`: decrement the hold counter. New pulses are OR-ed into `KEY_EVT` without reloading the counter. `KEY_EVT` clears when the counter reaches 0.
  - Simultaneous presses on several keys therefore appear together as a multi-bit code.
- Reset values: all outputs 0, synchronisers 0, all counters 0, all FSMs IDLE. After reset a button already held is accepted as a new press after debounce.

## Timing
- Latency from a raw edge held stable:
  - `s` changes 2 cycles after the edge.
  - `KEY_LEVEL` changes DB_CYCLES cycles after `s`.
  - `KEY_PRESS` rises 1 cycle after `KEY_LEVEL`.
  - `KEY_EVT` rises 1 cycle after `KEY_PRESS`.
  - Total edge to `KEY_EVT`: DB_CYCLES + 4 cycles.
- `KEY_EVT` is non-zero for exactly HOLD cycles per load. It then returns to 0 for at least 1 cycle before the next load.
- A pulse that arrives on the cycle `KEY_EVT` clears is not lost. It loads on the following cycle.
- The first repeat pulse comes REPEAT_DELAY cycles after the initial press pulse. Later repeats are REPEAT_RATE cycles apart. Repeat timing is exact while `KEY_LEVEL` stays 1.
- Release during WAIT or REPEAT: no further pulses from the cycle `KEY_LEVEL` falls.
- Asynchronous reset mid-count or mid-hold: outputs go to 0 immediately. Operation resumes from a clean state on the first edge after deassertion.

## Test plan
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, HOLD=3, ACTIVE_LOW=1.

- **Clean press.** Drive `KEY_RAW` 1111→1110 and hold.
  - `KEY_LEVEL` = 0001 at cycle 6.
  - `KEY_PRESS` = 0001 for 1 cycle at cycle 7.
  - `KEY_EVT` = 0001 for cycles 8–10, then 0000.
- **Bounce.** Toggle `KEY_RAW[1]` with 3-cycle low pulses separated by 1-cycle highs for 30 cycles, then release.
  - `KEY_LEVEL`, `KEY_PRESS` and `KEY_EVT` all stay 0.
- **Auto-repeat.** Hold `KEY_RAW[2]` low for 60 cycles.
  - Press pulse at T.
  - Repeat pulses at T+20, T+28, T+36, T+44, T+52.
  - `KEY_EVT` = 0100 for 3 cycles after each pulse.
  - Release: no pulses after `KEY_LEVEL` falls.
- **Simultaneous keys.** Press keys 0 and 3 on the same cycle.
  - `KEY_PRESS` = 1001 in one cycle.
  - `KEY_EVT` = 1001 for 3 cycles.
- **Staggered keys.** Key 3 press pulse arrives 1 cycle after key 0's.
  - `KEY_EVT` = 0001, then 1001, then 1001, then 0000.
- **Reset mid-hold.** Assert `HRESETn`=0 while `KEY_EVT` = 0001.
  - All outputs go to 0 at once.
  - Release reset with the key still held: a new press appears after DB_CYCLES + 4 cycles.
